// File: rtl/loss_accum_pkg.sv
// Shared definitions for the loss stage and the batch loss accumulator.
package loss_accum_pkg;

  // Handshake state reported by the upstream per-sample loss stage.
  // The encoding 2'b11 is unused and counts as "no valid sample".
  typedef enum logic [1:0] {
    LOSS_IDLE  = 2'b00,
    LOSS_BUSY  = 2'b01,
    LOSS_VALID = 2'b10
  } loss_state_e;

  // Control states of the batch accumulator.
  typedef enum logic [1:0] {
    ACC_IDLE    = 2'b00,
    ACC_COLLECT = 2'b01,
    ACC_DONE    = 2'b10
  } acc_state_e;

endpackage : loss_accum_pkg

// File: rtl/loss_accum.sv
// Batch mean-loss accumulator. It collects 2^batch_log2 per-sample losses
// from the upstream loss stage, sums them in a register wide enough that it
// cannot overflow, and presents the arithmetic mean (floor division by a
// power of two) until downstream accepts it.
module loss_accum
  import loss_accum_pkg::*;
#(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int MAXLOG = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [$clog2(MAXLOG+1)-1:0]     batch_log2,
  input  logic [1:0]                      loss_state,
  input  logic signed [IL+FL-1:0]         loss_out,
  output logic                            output_taken,
  output logic                            busy,
  output logic [MAXLOG:0]                 count,
  output logic signed [IL+FL-1:0]         result,
  output logic                            result_valid,
  input  logic                            result_ready
);

  localparam int W   = IL + FL;             // sample / result width
  localparam int AW  = W + MAXLOG;          // sum of 2^MAXLOG samples fits
  localparam int BLW = $clog2(MAXLOG + 1);  // batch_log2 width
  localparam int CW  = MAXLOG + 1;          // count holds up to 2^MAXLOG

  acc_state_e            state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BLW-1:0]        log2_q, log2_d;

  logic                  accept;
  logic [CW-1:0]         count_inc;
  logic [CW-1:0]         batch_n;
  logic [BLW-1:0]        log2_clamped;
  logic signed [AW-1:0]  loss_ext;

  // Sample handshake, batch size and sign-extended sample. Reset and abort
  // both veto the handshake so a sample is never half-consumed.
  always_comb begin
    accept       = (state_q == ACC_COLLECT) && (loss_state == LOSS_VALID)
                   && !abort && !reset;
    count_inc    = count_q + CW'(1);
    batch_n      = CW'(1) << log2_q;
    log2_clamped = (int'(batch_log2) > MAXLOG) ? BLW'(MAXLOG) : batch_log2;
    loss_ext     = {{MAXLOG{loss_out[W-1]}}, loss_out};
  end

  // Next-state and datapath update for the batch FSM.
  // NOTE: every target gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    log2_d  = log2_q;

    unique case (state_q)
      ACC_IDLE: begin
        if (start) begin
          state_d = ACC_COLLECT;
          log2_d  = log2_clamped;
          acc_d   = '0;
          count_d = '0;
        end
      end

      ACC_COLLECT: begin
        if (abort) begin
          state_d = ACC_IDLE;
          acc_d   = '0;
          count_d = '0;
        end else if (accept) begin
          acc_d   = acc_q + loss_ext;
          count_d = count_inc;
          if (count_inc == batch_n) begin
            state_d = ACC_DONE;
          end
        end
      end

      ACC_DONE: begin
        if (result_ready) begin
          state_d = ACC_IDLE;
          acc_d   = '0;
          count_d = '0;
        end
      end

      default: begin
        state_d = ACC_IDLE;
        acc_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      log2_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      log2_q  <= log2_d;
    end
  end

  // Outputs. The mean is an arithmetic shift of the signed sum, so it rounds
  // toward minus infinity; the mean of in-range samples always fits in W bits.
  always_comb begin
    output_taken = accept;
    busy         = (state_q != ACC_IDLE);
    count        = count_q;
    result_valid = (state_q == ACC_DONE);
    result       = (state_q == ACC_DONE) ? W'(acc_q >>> log2_q) : '0;
  end

endmodule : loss_accum

// File: doc/loss_accum.md
LOSS_ACCUM -- requirements
Module: loss_accum

Interface
REQ-001 SHALL have parameter IL, default 4, integer bits of the signed fixed-point loss format.
REQ-002 SHALL have parameter FL, default 16, fractional bits of the signed fixed-point loss format.
REQ-003 SHALL have parameter MAXLOG, default 7, maximum batch_log2; the largest batch is 2^MAXLOG samples.
REQ-004 SHALL have port clk, input, 1 bit, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, begins a batch when in IDLE.
REQ-007 SHALL have port abort, input, 1 bit, discards the batch in progress.
REQ-008 SHALL have port batch_log2, input, $clog2(MAXLOG+1) bits, batch size N = 2^batch_log2; sampled on an accepted start.
REQ-009 SHALL have port loss_state, input, 2 bits, upstream loss-stage state: 00 idle, 01 busy, 10 output valid.
REQ-010 SHALL have port loss_out, input, signed IL+FL bits, upstream per-sample loss.
REQ-011 SHALL have port output_taken, output, 1 bit, consume strobe to the upstream loss stage.
REQ-012 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-013 SHALL have port count, output, MAXLOG+1 bits, samples accepted in the current batch.
REQ-014 SHALL have port result, output, signed IL+FL bits, batch mean loss.
REQ-015 SHALL have port result_valid, output, 1 bit, result available.
REQ-016 SHALL have port result_ready, input, 1 bit, downstream accepts the result.

Function
REQ-017 SHALL implement the FSM states IDLE, COLLECT and DONE.
REQ-018 SHALL go IDLE->COLLECT on start; SHALL latch batch_log2 at that edge, clamping values above MAXLOG to MAXLOG.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL drive output_taken combinationally as (state==COLLECT && loss_state==10 && !abort).
REQ-021 SHALL, on the same edge as output_taken=1, add the sign-extended loss_out to the accumulator and increment count.
REQ-022 SHALL size the accumulator as signed IL+FL+MAXLOG bits so that it never overflows.
REQ-023 SHALL go COLLECT->DONE on the edge that accepts the sample taking count to N.
REQ-024 SHALL produce result_valid exactly 1 cycle after the N-th accept.
REQ-025 SHALL compute result = accumulator arithmetically right-shifted by batch_log2 (rounding toward minus infinity), truncated to IL+FL bits.
REQ-026 SHALL NOT saturate result; the mean of in-range samples always fits in IL+FL bits.
REQ-027 SHALL hold result_valid and result stable in DONE until result_ready=1.
REQ-028 SHALL, on the edge where result_ready=1 in DONE, go to IDLE and clear the accumulator and count.
REQ-029 SHALL keep output_taken at 0 in DONE and IDLE, so any pending upstream loss waits.
REQ-030 SHALL, on abort in COLLECT, go to IDLE and clear the accumulator and count; abort wins over a simultaneous accept.
REQ-031 SHALL ignore abort in IDLE and DONE.
REQ-032 SHALL treat a loss_state value of 11 as not valid.

Reset
REQ-033 SHALL on reset set state=IDLE, accumulator=0, count=0 and latched batch_log2=0.
REQ-034 SHALL on reset set output_taken=0, busy=0, result_valid=0 and result=0.
REQ-035 SHALL take reset over all other inputs, including mid-batch, with no sample accepted in that cycle.

Structure
REQ-036 SHALL place in the shared loss package the loss-stage state encoding (LOSS_IDLE=00, LOSS_BUSY=01, LOSS_VALID=10).
REQ-037 SHALL place in the shared loss package the FSM state enum for this block.
REQ-038 SHALL implement as a single module with no sub-modules.

Verification
REQ-039 SHALL verify basic mean: batch_log2=2, losses 1.0, 2.0, 3.0, 2.0 (0x10000, 0x20000, 0x30000, 0x20000) -> result=0x20000, result_valid 1 cycle after the 4th accept.
REQ-040 SHALL verify rounding: batch_log2=1, losses 0x00001 and 0x00000 -> result 0x00000; losses 0xFFFFF and 0x00000 -> result 0xFFFFF.
REQ-041 SHALL verify single sample: batch_log2=0, loss -1.5 (0xE8000) -> result 0xE8000.
REQ-042 SHALL verify backpressure: result_ready low for 5 cycles with loss_state=10 -> result stable, output_taken=0 throughout; result_ready=1 -> IDLE next cycle.
REQ-043 SHALL verify abort: abort after 2 of 4 samples, coinciding with loss_state=10 -> output_taken=0 and count=0; a new batch of four 0x10000 -> result=0x10000.
REQ-044 SHALL verify reset mid-batch: reset asserted in COLLECT with count=3 -> next cycle busy=0, count=0, result_valid=0.
